// File: rtl/dynamic_decoder_multi.sv
// Multi-lane dynamic decode stage: privilege/CSR fault check, bundle
// truncation at the first fault, sequential ID assignment, and a registered
// valid/ready output bundle.

package RV;
  typedef enum logic [1:0] {
    Off     = 2'd0,
    Initial = 2'd1,
    Clean   = 2'd2,
    Dirty   = 2'd3
  } xs_t;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;
endpackage

package dd_pkg;
  typedef enum logic [2:0] {
    FU_NONE, FU_ALU, FU_BRANCH, FU_LSU, FU_CSR, FU_FPU
  } fu_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SRET, OP_MRET, OP_DRET, OP_WFI, OP_FENCE_VMA, OP_FADD
  } op_t;

  typedef struct packed {
    fu_t        fu;
    op_t        op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } si_t;

  // ID field is sized for the widest supported counter; the upper bits
  // above ID_WIDTH are always zero.
  localparam int unsigned ID_MAX_W = 32;

  typedef struct packed {
    si_t                 si;
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic                fault;
  } di_t;
endpackage

module dynamic_decoder_multi #(
  parameter int unsigned NLANES   = 2,
  parameter int unsigned ID_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_i,
  input  logic [NLANES-1:0]           lane_mask_i,
  input  dd_pkg::si_t [NLANES-1:0]    si_i,
  output logic                        ready_o,
  input  logic                        flush_i,
  input  RV::xs_t                     fs_i,
  input  RV::priv_lvl_t               priv_lvl_i,
  input  logic [2:0]                  frm_i,
  input  logic                        tvm_i,
  input  logic                        tw_i,
  input  logic                        tsr_i,
  input  logic                        debug_mode_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output dd_pkg::di_t [NLANES-1:0]    di_o,
  output logic [NLANES-1:0][2:0]      cause_o
);
  import RV::*;
  import dd_pkg::*;

  logic [ID_WIDTH-1:0]              cnt;
  logic [NLANES-1:0][2:0]           lane_cause;
  logic [NLANES-1:0]                surv;
  logic [NLANES-1:0]                lane_fault;
  logic [NLANES-1:0][2:0]           cause_n;
  logic [NLANES-1:0][ID_WIDTH-1:0]  lane_id;
  logic [ID_WIDTH-1:0]              n_surv;
  logic                             stop;
  logic                             accept;

  assign ready_o = !flush_i && (!valid_o || ready_i);
  assign accept  = valid_i && ready_o;

  // Per-lane fault cause; if/else order gives the lowest code priority.
  always_comb begin
    lane_cause = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      if (si_i[i].op == OP_SRET &&
          (priv_lvl_i == PRIV_LVL_U || (priv_lvl_i == PRIV_LVL_S && tsr_i)))
        lane_cause[i] = 3'd1;
      else if (si_i[i].op == OP_MRET && priv_lvl_i != PRIV_LVL_M)
        lane_cause[i] = 3'd2;
      else if (si_i[i].op == OP_DRET && !debug_mode_i)
        lane_cause[i] = 3'd3;
      else if (si_i[i].op == OP_WFI &&
               (priv_lvl_i == PRIV_LVL_U || (priv_lvl_i == PRIV_LVL_S && tw_i)))
        lane_cause[i] = 3'd4;
      else if (si_i[i].op == OP_FENCE_VMA &&
               (priv_lvl_i == PRIV_LVL_U || (priv_lvl_i == PRIV_LVL_S && tvm_i)))
        lane_cause[i] = 3'd5;
      else if (si_i[i].fu == FU_FPU && fs_i == Off)
        lane_cause[i] = 3'd6;
      else if (si_i[i].fu == FU_FPU && frm_i >= 3'd5)
        lane_cause[i] = 3'd7;
    end
  end

  // Walk lanes in order: keep occupied lanes up to and including the first
  // faulting one, numbering survivors from the current counter.
  always_comb begin
    surv       = '0;
    lane_fault = '0;
    cause_n    = '0;
    lane_id    = '0;
    n_surv     = '0;
    stop       = 1'b0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      if (lane_mask_i[i] && !stop) begin
        surv[i]    = 1'b1;
        lane_id[i] = cnt + n_surv;
        n_surv     = n_surv + ID_WIDTH'(1);
        if (lane_cause[i] != 3'd0) begin
          stop          = 1'b1;
          lane_fault[i] = 1'b1;
          cause_n[i]    = lane_cause[i];
        end
      end
    end
  end

  // Output register and ID counter; reset > flush > accept > transfer-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      cnt     <= '0;
      di_o    <= '0;
      cause_o <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      for (int unsigned i = 0; i < NLANES; i++) begin
        di_o[i].valid <= 1'b0;
      end
    end else if (accept) begin
      valid_o <= 1'b1;
      cnt     <= cnt + n_surv;
      cause_o <= cause_n;
      for (int unsigned i = 0; i < NLANES; i++) begin
        di_o[i].si    <= si_i[i];
        di_o[i].valid <= surv[i];
        di_o[i].id    <= ID_MAX_W'(lane_id[i]);
        di_o[i].fault <= lane_fault[i];
      end
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dynamic_decoder_multi.sv
// Directed self-checking bench for dynamic_decoder_multi (NLANES=2), with a
// second narrow-counter instance used for the ID wrap scenario.
module tb_dynamic_decoder_multi;
  import RV::*;
  import dd_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_i;
  logic [1:0]         lane_mask_i;
  si_t  [1:0]         si_i;
  logic               flush_i;
  xs_t                fs_i;
  priv_lvl_t          priv_lvl_i;
  logic [2:0]         frm_i;
  logic               tvm_i, tw_i, tsr_i, debug_mode_i;
  logic               ready_i;

  logic               ready_o, valid_o;
  di_t  [1:0]         di_o;
  logic [1:0][2:0]    cause_o;

  logic               ready_o_w, valid_o_w;
  di_t  [1:0]         di_o_w;
  logic [1:0][2:0]    cause_o_w;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  dynamic_decoder_multi #(.NLANES(2), .ID_WIDTH(20)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .lane_mask_i(lane_mask_i),
    .si_i(si_i), .ready_o(ready_o), .flush_i(flush_i), .fs_i(fs_i),
    .priv_lvl_i(priv_lvl_i), .frm_i(frm_i), .tvm_i(tvm_i), .tw_i(tw_i),
    .tsr_i(tsr_i), .debug_mode_i(debug_mode_i), .valid_o(valid_o),
    .ready_i(ready_i), .di_o(di_o), .cause_o(cause_o)
  );

  dynamic_decoder_multi #(.NLANES(2), .ID_WIDTH(3)) dut_w (
    .clk(clk), .rst(rst), .valid_i(valid_i), .lane_mask_i(lane_mask_i),
    .si_i(si_i), .ready_o(ready_o_w), .flush_i(flush_i), .fs_i(fs_i),
    .priv_lvl_i(priv_lvl_i), .frm_i(frm_i), .tvm_i(tvm_i), .tw_i(tw_i),
    .tsr_i(tsr_i), .debug_mode_i(debug_mode_i), .valid_o(valid_o_w),
    .ready_i(ready_i), .di_o(di_o_w), .cause_o(cause_o_w)
  );

  function automatic si_t mk(input fu_t fu, input op_t op, input logic [4:0] rd);
    si_t s;
    s.fu  = fu;
    s.op  = op;
    s.rd  = rd;
    s.rs1 = 5'd1;
    s.rs2 = 5'd2;
    return s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic v, input logic [1:0] m, input si_t s0, input si_t s1);
    valid_i     = v;
    lane_mask_i = m;
    si_i[0]     = s0;
    si_i[1]     = s1;
  endtask

  task automatic csr_default;
    fs_i = Dirty; priv_lvl_i = PRIV_LVL_M; frm_i = 3'd0;
    tvm_i = 1'b0; tw_i = 1'b0; tsr_i = 1'b0; debug_mode_i = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    csr_default;
    set_bundle(1'b0, 2'b00, mk(FU_NONE, OP_NOP, 0), mk(FU_NONE, OP_NOP, 0));
    do_reset;
    n_checks++; if (valid_o !== 1'b0) begin n_fails++; $display("FAIL reset_valid_o: got %0b expected 0", valid_o); end
    n_checks++; if (di_o !== '0) begin n_fails++; $display("FAIL reset_di_o: got %h expected 0", di_o); end
    n_checks++; if (cause_o !== '0) begin n_fails++; $display("FAIL reset_cause_o: got %h expected 0", cause_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fails++; $display("FAIL reset_ready_o: got %0b expected 1", ready_o); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    set_bundle(1'b1, 2'b11, mk(FU_ALU, OP_ADD, 5'd1), mk(FU_ALU, OP_ADD, 5'd2));
    for (int b = 0; b < 3; b++) begin
      tick;
      n_checks++; if (valid_o !== 1'b1) begin n_fails++; $display("FAIL b2b_valid[%0d]: got %0b expected 1", b, valid_o); end
      n_checks++; if (di_o[0].id !== 32'(2*b) || di_o[1].id !== 32'(2*b+1))
        begin n_fails++; $display("FAIL b2b_ids[%0d]: got %0d,%0d expected %0d,%0d", b, di_o[0].id, di_o[1].id, 2*b, 2*b+1); end
      n_checks++; if (di_o[0].si.rd !== 5'(2*b+1) || di_o[1].si.rd !== 5'(2*b+2) || di_o[1].valid !== 1'b1)
        begin n_fails++; $display("FAIL b2b_si[%0d]: got rd %0d,%0d v%0b expected %0d,%0d v1", b, di_o[0].si.rd, di_o[1].si.rd, di_o[1].valid, 2*b+1, 2*b+2); end
      n_checks++; if (ready_o !== 1'b1) begin n_fails++; $display("FAIL b2b_ready[%0d]: got %0b expected 1", b, ready_o); end
      set_bundle(1'b1, 2'b11, mk(FU_ALU, OP_ADD, 5'(2*b+3)), mk(FU_ALU, OP_ADD, 5'(2*b+4)));
    end
    valid_i = 1'b0;
    tick;
    n_checks++; if (valid_o !== 1'b0) begin n_fails++; $display("FAIL b2b_drain: got %0b expected 0", valid_o); end
  endtask

  task automatic test_priv_faults;
    do_reset;
    csr_default;
    // MRET in S: lane 0 faults, lane 1 dropped
    priv_lvl_i = PRIV_LVL_S;
    set_bundle(1'b1, 2'b11, mk(FU_CSR, OP_MRET, 5'd0), mk(FU_ALU, OP_ADD, 5'd5));
    tick;
    n_checks++; if (di_o[0].valid !== 1'b1 || di_o[0].fault !== 1'b1 || cause_o[0] !== 3'd2 || di_o[0].id !== 32'd0)
      begin n_fails++; $display("FAIL mret_lane0: got v%0b f%0b c%0d id%0d expected v1 f1 c2 id0", di_o[0].valid, di_o[0].fault, cause_o[0], di_o[0].id); end
    n_checks++; if (di_o[1].valid !== 1'b0 || cause_o[1] !== 3'd0)
      begin n_fails++; $display("FAIL mret_lane1_drop: got v%0b c%0d expected v0 c0", di_o[1].valid, cause_o[1]); end
    // SRET in S with tsr in lane 1
    tsr_i = 1'b1;
    set_bundle(1'b1, 2'b11, mk(FU_ALU, OP_ADD, 5'd6), mk(FU_CSR, OP_SRET, 5'd0));
    tick;
    n_checks++; if (di_o[0].id !== 32'd1 || di_o[0].fault !== 1'b0 || cause_o[0] !== 3'd0)
      begin n_fails++; $display("FAIL sret_lane0: got id%0d f%0b c%0d expected id1 f0 c0", di_o[0].id, di_o[0].fault, cause_o[0]); end
    n_checks++; if (di_o[1].valid !== 1'b1 || di_o[1].fault !== 1'b1 || cause_o[1] !== 3'd1 || di_o[1].id !== 32'd2)
      begin n_fails++; $display("FAIL sret_lane1: got v%0b f%0b c%0d id%0d expected v1 f1 c1 id2", di_o[1].valid, di_o[1].fault, cause_o[1], di_o[1].id); end
    // WFI in U
    tsr_i = 1'b0; priv_lvl_i = PRIV_LVL_U;
    set_bundle(1'b1, 2'b11, mk(FU_CSR, OP_WFI, 5'd0), mk(FU_ALU, OP_ADD, 5'd7));
    tick;
    n_checks++; if (cause_o[0] !== 3'd4 || di_o[0].id !== 32'd3 || di_o[1].valid !== 1'b0)
      begin n_fails++; $display("FAIL wfi_u: got c%0d id%0d v1=%0b expected c4 id3 v1=0", cause_o[0], di_o[0].id, di_o[1].valid); end
    // DRET outside debug mode, even in M
    priv_lvl_i = PRIV_LVL_M;
    set_bundle(1'b1, 2'b11, mk(FU_CSR, OP_DRET, 5'd0), mk(FU_ALU, OP_ADD, 5'd8));
    tick;
    n_checks++; if (cause_o[0] !== 3'd3 || di_o[0].id !== 32'd4 || di_o[1].valid !== 1'b0)
      begin n_fails++; $display("FAIL dret: got c%0d id%0d v1=%0b expected c3 id4 v1=0", cause_o[0], di_o[0].id, di_o[1].valid); end
    // FENCE_VMA in S with tvm
    priv_lvl_i = PRIV_LVL_S; tvm_i = 1'b1;
    set_bundle(1'b1, 2'b11, mk(FU_ALU, OP_ADD, 5'd9), mk(FU_CSR, OP_FENCE_VMA, 5'd0));
    tick;
    n_checks++; if (cause_o[1] !== 3'd5 || di_o[1].id !== 32'd6 || di_o[0].id !== 32'd5 || di_o[0].fault !== 1'b0)
      begin n_fails++; $display("FAIL fence_vma: got c%0d ids %0d,%0d f0=%0b expected c5 ids 5,6 f0=0", cause_o[1], di_o[0].id, di_o[1].id, di_o[0].fault); end
    // Clean bundle: MRET legal in M
    csr_default;
    set_bundle(1'b1, 2'b11, mk(FU_CSR, OP_MRET, 5'd0), mk(FU_ALU, OP_ADD, 5'd10));
    tick;
    n_checks++; if (di_o[0].fault !== 1'b0 || cause_o !== '0 || di_o[0].id !== 32'd7 || di_o[1].id !== 32'd8 || di_o[1].valid !== 1'b1)
      begin n_fails++; $display("FAIL clean_after_faults: got f%0b c%h ids %0d,%0d expected f0 c0 ids 7,8", di_o[0].fault, cause_o, di_o[0].id, di_o[1].id); end
    valid_i = 1'b0;
    tick;
  endtask

  task automatic test_fpu;
    // counter is 9 here
    csr_default;
    fs_i = Off;
    set_bundle(1'b1, 2'b11, mk(FU_ALU, OP_ADD, 5'd1), mk(FU_FPU, OP_FADD, 5'd2));
    tick;
    n_checks++; if (cause_o[1] !== 3'd6 || di_o[1].fault !== 1'b1 || di_o[0].fault !== 1'b0 || di_o[1].id !== 32'd10)
      begin n_fails++; $display("FAIL fpu_off: got c%0d f1=%0b f0=%0b id%0d expected c6 f1=1 f0=0 id10", cause_o[1], di_o[1].fault, di_o[0].fault, di_o[1].id); end
    fs_i = Dirty; frm_i = 3'd5;
    tick;
    n_checks++; if (cause_o[1] !== 3'd7 || di_o[1].id !== 32'd12)
      begin n_fails++; $display("FAIL fpu_frm5: got c%0d id%0d expected c7 id12", cause_o[1], di_o[1].id); end
    fs_i = Off; frm_i = 3'd6;
    tick;
    n_checks++; if (cause_o[1] !== 3'd6)
      begin n_fails++; $display("FAIL fpu_priority: got c%0d expected c6", cause_o[1]); end
    fs_i = Dirty; frm_i = 3'd0;
    tick;
    n_checks++; if (cause_o !== '0 || di_o[1].fault !== 1'b0 || di_o[1].valid !== 1'b1 || di_o[1].id !== 32'd16)
      begin n_fails++; $display("FAIL fpu_ok: got c%h f%0b v%0b id%0d expected c0 f0 v1 id16", cause_o, di_o[1].fault, di_o[1].valid, di_o[1].id); end
    valid_i = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    do_reset;
    csr_default;
    set_bundle(1'b1, 2'b11, mk(FU_CSR, OP_MRET, 5'd1), mk(FU_ALU, OP_ADD, 5'd2));
    tick;
    // held bundle must not react to later CSR changes
    ready_i = 1'b0; priv_lvl_i = PRIV_LVL_S;
    set_bundle(1'b1, 2'b11, mk(FU_ALU, OP_ADD, 5'd3), mk(FU_ALU, OP_ADD, 5'd4));
    #1;
    n_checks++; if (ready_o !== 1'b0) begin n_fails++; $display("FAIL bp_ready_low: got %0b expected 0", ready_o); end
    for (int c = 0; c < 4; c++) begin
      tick;
      n_checks++; if (valid_o !== 1'b1 || ready_o !== 1'b0 || di_o[0].id !== 32'd0 || di_o[0].si.rd !== 5'd1 || di_o[1].id !== 32'd1 || di_o[0].fault !== 1'b0 || cause_o !== '0)
        begin n_fails++; $display("FAIL bp_hold[%0d]: got v%0b r%0b ids %0d,%0d rd%0d f%0b c%h expected v1 r0 ids 0,1 rd1 f0 c0", c, valid_o, ready_o, di_o[0].id, di_o[1].id, di_o[0].si.rd, di_o[0].fault, cause_o); end
    end
    ready_i = 1'b1;
    #1;
    n_checks++; if (ready_o !== 1'b1) begin n_fails++; $display("FAIL bp_ready_release: got %0b expected 1", ready_o); end
    tick;
    n_checks++; if (valid_o !== 1'b1 || di_o[0].id !== 32'd2 || di_o[1].id !== 32'd3 || di_o[0].si.rd !== 5'd3)
      begin n_fails++; $display("FAIL bp_next: got v%0b ids %0d,%0d rd%0d expected v1 ids 2,3 rd3", valid_o, di_o[0].id, di_o[1].id, di_o[0].si.rd); end
    valid_i = 1'b0;
    tick;
    n_checks++; if (valid_o !== 1'b0) begin n_fails++; $display("FAIL bp_drain: got %0b expected 0", valid_o); end
  endtask

  task automatic test_flush_and_empty;
    do_reset;
    csr_default;
    set_bundle(1'b1, 2'b11, mk(FU_ALU, OP_ADD, 5'd1), mk(FU_ALU, OP_ADD, 5'd2));
    tick;
    flush_i = 1'b1;
    set_bundle(1'b1, 2'b11, mk(FU_ALU, OP_ADD, 5'd9), mk(FU_ALU, OP_ADD, 5'd10));
    #1;
    n_checks++; if (ready_o !== 1'b0) begin n_fails++; $display("FAIL flush_ready: got %0b expected 0", ready_o); end
    tick;
    n_checks++; if (valid_o !== 1'b0 || di_o[0].valid !== 1'b0 || di_o[1].valid !== 1'b0)
      begin n_fails++; $display("FAIL flush_clear: got v%0b lanes %0b%0b expected v0 lanes 00", valid_o, di_o[1].valid, di_o[0].valid); end
    flush_i = 1'b0;
    tick;
    n_checks++; if (valid_o !== 1'b1 || di_o[0].id !== 32'd2 || di_o[1].id !== 32'd3 || di_o[0].si.rd !== 5'd9)
      begin n_fails++; $display("FAIL flush_resume: got v%0b ids %0d,%0d rd%0d expected v1 ids 2,3 rd9", valid_o, di_o[0].id, di_o[1].id, di_o[0].si.rd); end
    // empty bundle: accepted, no lanes, no IDs consumed
    lane_mask_i = 2'b00;
    tick;
    n_checks++; if (valid_o !== 1'b1 || di_o[0].valid !== 1'b0 || di_o[1].valid !== 1'b0)
      begin n_fails++; $display("FAIL empty_mask: got v%0b lanes %0b%0b expected v1 lanes 00", valid_o, di_o[1].valid, di_o[0].valid); end
    lane_mask_i = 2'b01;
    tick;
    n_checks++; if (di_o[0].valid !== 1'b1 || di_o[0].id !== 32'd4 || di_o[1].valid !== 1'b0)
      begin n_fails++; $display("FAIL single_lane: got v0=%0b id%0d v1=%0b expected v0=1 id4 v1=0", di_o[0].valid, di_o[0].id, di_o[1].valid); end
    valid_i = 1'b0;
    tick;
  endtask

  task automatic test_reset_midstream;
    do_reset;
    csr_default;
    set_bundle(1'b1, 2'b11, mk(FU_ALU, OP_ADD, 5'd1), mk(FU_ALU, OP_ADD, 5'd2));
    tick;
    tick;
    rst = 1'b1; flush_i = 1'b1; ready_i = 1'b0;
    tick;
    n_checks++; if (valid_o !== 1'b0 || di_o !== '0 || cause_o !== '0)
      begin n_fails++; $display("FAIL mid_reset: got v%0b di %h c%h expected all 0", valid_o, di_o, cause_o); end
    rst = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    tick;
    n_checks++; if (valid_o !== 1'b1 || di_o[0].id !== 32'd0 || di_o[1].id !== 32'd1)
      begin n_fails++; $display("FAIL mid_reset_ids: got v%0b ids %0d,%0d expected v1 ids 0,1", valid_o, di_o[0].id, di_o[1].id); end
    valid_i = 1'b0;
    tick;
  endtask

  task automatic test_wrap;
    do_reset;
    csr_default;
    set_bundle(1'b1, 2'b11, mk(FU_ALU, OP_ADD, 5'd1), mk(FU_ALU, OP_ADD, 5'd2));
    tick; tick; tick;
    lane_mask_i = 2'b01;
    tick;
    n_checks++; if (di_o_w[0].id !== 32'd6 || di_o_w[1].valid !== 1'b0)
      begin n_fails++; $display("FAIL wrap_pre: got id%0d v1=%0b expected id6 v1=0", di_o_w[0].id, di_o_w[1].valid); end
    lane_mask_i = 2'b11;
    tick;
    n_checks++; if (di_o_w[0].id !== 32'd7 || di_o_w[1].id !== 32'd0 || di_o_w[1].valid !== 1'b1)
      begin n_fails++; $display("FAIL wrap_ids: got %0d,%0d v1=%0b expected 7,0 v1=1", di_o_w[0].id, di_o_w[1].id, di_o_w[1].valid); end
    n_checks++; if (di_o[0].id !== 32'd7 || di_o[1].id !== 32'd8)
      begin n_fails++; $display("FAIL wide_no_wrap: got %0d,%0d expected 7,8", di_o[0].id, di_o[1].id); end
    lane_mask_i = 2'b01;
    tick;
    n_checks++; if (di_o_w[0].id !== 32'd1 || valid_o_w !== 1'b1)
      begin n_fails++; $display("FAIL wrap_after: got id%0d v%0b expected id1 v1", di_o_w[0].id, valid_o_w); end
    valid_i = 1'b0;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_back_to_back;
    test_priv_faults;
    test_fpu;
    test_backpressure;
    test_flush_and_empty;
    test_reset_midstream;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
